consumer: RTL and testbench

Read-side counterpart of `producer`. It drains words from the read port of the shared data FIFO on behalf of a downstream requester. The block issues single-cycle FIFO pops only when the FIFO is non-empty and captures the returned word into a holding register. It then presents that word with a one-cycle valid strobe and keeps a running count of delivered words. It runs entirely in the read clock domain.

---
 rtl/consumer_if.sv | 39 +++
 rtl/consumer.sv | 86 ++++++++
 tb/tb_consumer.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/consumer_if.sv
// consumer_if: groups the FIFO read-port and downstream requester signals
// of the consumer block.
//
// Signals:
//   rd_req   - downstream read request (level)
//   f_empty  - FIFO empty flag, already in the read clock domain
//   f_data   - FIFO read data, valid the cycle after a sampled pop
//   r_en     - FIFO pop strobe
//   d_out    - last delivered word
//   d_valid  - one-cycle strobe marking a fresh d_out
//   rd_count - delivered-word counter, wraps
//   starve   - requester is waiting on an empty FIFO
//
// Modports:
//   slave  - the consumer block itself
//   master - whatever drives requests and FIFO status (FIFO + requester)
interface consumer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  logic                  rd_req;
  logic                  f_empty;
  logic [DATA_WIDTH-1:0] f_data;
  logic                  r_en;
  logic [DATA_WIDTH-1:0] d_out;
  logic                  d_valid;
  logic [CNT_WIDTH-1:0]  rd_count;
  logic                  starve;

  modport slave (
    input  rd_req, f_empty, f_data,
    output r_en, d_out, d_valid, rd_count, starve
  );

  modport master (
    output rd_req, f_empty, f_data,
    input  r_en, d_out, d_valid, rd_count, starve
  );
endinterface

// File: rtl/consumer.sv
// consumer: read-side drain engine for the shared data FIFO.
//
// Waits in IDLE for a downstream request while the FIFO is non-empty,
// issues a single-cycle pop (POP), captures the word the FIFO returns one
// cycle later (CAPTURE), then presents it on d_out with a one-cycle d_valid
// strobe and bumps the wrapping delivered-word counter. Best case is one
// word every three cycles.
//
// Ports:
//   r_clk - read-domain clock, rising edge
//   rrst  - synchronous active-high reset
//   bus   - consumer_if.slave: rd_req, f_empty, f_data in;
//           r_en, d_out, d_valid, rd_count, starve out (all registered)
module consumer #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic       r_clk,
  input  logic       rrst,
  consumer_if.slave  bus
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] POP     = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]            state_reg;
  logic                  r_en_reg;
  logic [DATA_WIDTH-1:0] d_out_reg;
  logic                  d_valid_reg;
  logic [CNT_WIDTH-1:0]  rd_count_reg;
  logic                  starve_reg;

  // Pop decision: only ever taken with the FIFO reporting non-empty at the
  // deciding edge, so the FIFO can never underflow.
  logic take;
  assign take = bus.rd_req & ~bus.f_empty;

  always_ff @(posedge r_clk) begin
    if (rrst) begin
      state_reg    <= IDLE;
      r_en_reg     <= 1'b0;
      d_out_reg    <= '0;
      d_valid_reg  <= 1'b0;
      rd_count_reg <= '0;
      starve_reg   <= 1'b0;
    end else begin
      // Strobes default low; starve is only re-evaluated in IDLE.
      r_en_reg    <= 1'b0;
      d_valid_reg <= 1'b0;
      starve_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          starve_reg <= bus.rd_req & bus.f_empty;
          if (take) begin
            state_reg <= POP;
            // Registered so the pop is high exactly for the POP cycle.
            r_en_reg  <= 1'b1;
          end
        end
        POP: begin
          // Committed: a late drop of rd_req does not cancel the word.
          state_reg <= CAPTURE;
        end
        CAPTURE: begin
          d_out_reg    <= bus.f_data;
          d_valid_reg  <= 1'b1;
          rd_count_reg <= rd_count_reg + CNT_ONE;
          state_reg    <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.r_en     = r_en_reg;
  assign bus.d_out    = d_out_reg;
  assign bus.d_valid  = d_valid_reg;
  assign bus.rd_count = rd_count_reg;
  assign bus.starve   = starve_reg;

endmodule

// File: tb/tb_consumer.sv
// tb_consumer: self-checking bench for consumer.
//
// A queue-based FIFO model serves pops; every popped word is pushed onto an
// expected-delivery queue, and each d_valid strobe must deliver the head of
// that queue with rd_count equal to the number of deliveries modulo the
// counter range. The counter is instantiated narrow so its wrap is reached
// quickly.
module tb_consumer;

  localparam int DW   = 32;
  localparam int CW   = 8;
  localparam int CMOD = 1 << CW;

  logic r_clk = 1'b0;
  logic rrst  = 1'b1;

  consumer_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  consumer #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .r_clk (r_clk),
    .rrst  (rrst),
    .bus   (bus)
  );

  always #5 r_clk = ~r_clk;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] pop_word;
  logic [DW-1:0] exp_word;

  bit cur_req     = 1'b0;
  bit force_empty = 1'b0;
  bit last_empty  = 1'b1;
  bit mon_en      = 1'b0;
  bit stream_mode = 1'b0;

  int underflows = 0;
  int bad_dec    = 0;
  int pops       = 0;
  int cycle      = 0;
  int delivered  = 0;
  int last_valid = -1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change only on the falling edge; f_empty reflects the model.
  task automatic drive(input bit req, input bit fe);
    @(negedge r_clk);
    cur_req     = req;
    force_empty = fe;
    bus.rd_req  = req;
    bus.f_empty = fe || (fifo_q.size() == 0);
  endtask

  task automatic wait_delivered(input int target, input int budget);
    int n;
    n = 0;
    while (delivered < target && n < budget) begin
      drive(cur_req, force_empty);
      n++;
    end
    if (delivered < target) check("timeout_deliveries", delivered, target);
  endtask

  // FIFO model: a pop sampled at this edge returns data for the next cycle.
  always @(posedge r_clk) begin
    cycle++;
    if (!rrst && bus.r_en) begin
      pops++;
      if (last_empty) bad_dec++;
      if (fifo_q.size() == 0) begin
        underflows++;
      end else begin
        pop_word = fifo_q.pop_front();
        bus.f_data <= pop_word;
        exp_q.push_back(pop_word);
      end
    end
    last_empty = bus.f_empty;
  end

  // Delivery scoreboard.
  always @(negedge r_clk) begin
    if (mon_en && bus.d_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_d_valid", bus.d_valid, 1'b0);
      end else begin
        delivered++;
        exp_word = exp_q.pop_front();
        $display("[TB] delivery %0d d_out=%08h rd_count=%0d", delivered, bus.d_out, bus.rd_count);
        check("d_out", bus.d_out, exp_word);
        check("rd_count", bus.rd_count, delivered % CMOD);
        if (stream_mode && last_valid >= 0) check("spacing", cycle - last_valid, 3);
        last_valid = cycle;
      end
    end
  end

  initial begin
    int target;
    int p0;
    bus.rd_req  = 1'b0;
    bus.f_empty = 1'b1;
    bus.f_data  = '0;

    // Reset hold with random inputs.
    for (int i = 0; i < 10; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      check("rst_r_en", bus.r_en, 1'b0);
      check("rst_d_valid", bus.d_valid, 1'b0);
      check("rst_starve", bus.starve, 1'b0);
      check("rst_d_out", bus.d_out, '0);
      check("rst_rd_count", bus.rd_count, '0);
    end
    drive(1'b0, 1'b0);
    rrst   = 1'b0;
    mon_en = 1'b1;
    drive(1'b0, 1'b0);

    // Single read from a one-cycle request pulse.
    fifo_q.push_back(32'hDEADBEEF);
    p0 = pops;
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    check("single_r_en_high", bus.r_en, 1'b1);
    check("single_starve", bus.starve, 1'b0);
    drive(1'b0, 1'b0);
    check("single_r_en_low", bus.r_en, 1'b0);
    check("single_no_early_valid", bus.d_valid, 1'b0);
    drive(1'b0, 1'b0);
    check("single_d_valid", bus.d_valid, 1'b1);
    check("single_d_out", bus.d_out, 32'hDEADBEEF);
    check("single_rd_count", bus.rd_count, 1);
    drive(1'b0, 1'b0);
    check("single_valid_drop", bus.d_valid, 1'b0);
    check("single_d_out_held", bus.d_out, 32'hDEADBEEF);
    check("single_pop_count", pops - p0, 1);

    // Streaming 100 random words with rd_req held.
    for (int i = 0; i < 100; i++) fifo_q.push_back($urandom);
    target      = delivered + 100;
    stream_mode = 1'b1;
    last_valid  = -1;
    drive(1'b1, 1'b0);
    wait_delivered(target, 400);
    stream_mode = 1'b0;
    check("stream_underflows", underflows, 0);
    check("stream_rd_count", bus.rd_count, target % CMOD);
    check("stream_drained", fifo_q.size(), 0);

    // Empty stall, then release.
    drive(1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b0);
      check("stall_r_en", bus.r_en, 1'b0);
      if (i > 0) check("stall_starve", bus.starve, 1'b1);
    end
    fifo_q.push_back($urandom);
    target = delivered + 1;
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b0);
    check("release_starve", bus.starve, 1'b0);
    check("release_r_en", bus.r_en, 1'b1);
    drive(1'b0, 1'b0);
    wait_delivered(target, 10);

    // Alternating empty flag with rd_req held.
    for (int i = 0; i < 20; i++) fifo_q.push_back($urandom);
    target = delivered + 20;
    for (int i = 0; i < 90; i++) drive(1'b1, (i % 2) == 0);
    drive(1'b1, 1'b0);
    wait_delivered(target, 100);
    check("alt_bad_decisions", bad_dec, 0);
    check("alt_underflows", underflows, 0);
    check("alt_drained", fifo_q.size(), 0);

    // Reset during CAPTURE discards the popped word.
    drive(1'b0, 1'b0);
    fifo_q.push_back(32'hCAFEF00D);
    mon_en = 1'b0;
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    rrst = 1'b1;
    drive(1'b0, 1'b0);
    check("midrst_d_valid", bus.d_valid, 1'b0);
    check("midrst_rd_count", bus.rd_count, '0);
    check("midrst_d_out", bus.d_out, '0);
    check("midrst_r_en", bus.r_en, 1'b0);
    check("midrst_starve", bus.starve, 1'b0);
    rrst = 1'b0;
    exp_q.delete();
    fifo_q.delete();
    delivered = 0;
    mon_en    = 1'b1;
    drive(1'b0, 1'b0);

    // Counter wrap: stream past the counter range.
    for (int i = 0; i < 260; i++) fifo_q.push_back($urandom);
    stream_mode = 1'b1;
    last_valid  = -1;
    drive(1'b1, 1'b0);
    wait_delivered(260, 900);
    stream_mode = 1'b0;
    check("wrap_rd_count", bus.rd_count, 260 % CMOD);
    drive(1'b0, 1'b0);
    repeat (4) drive(1'b0, 1'b0);
    check("final_pending", exp_q.size(), 0);
    check("final_underflows", underflows, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
